// File: rtl/mul_pkg.sv
// Shared types and helpers for the shared shift-add multiplier scheduler.
// Holds the FSM state enum, default sizes and the round-robin pick function.
package mul_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Index of the first asserted valid at or above ptr, wrapping modulo nreq.
    // Returns 0 when nothing is valid; callers qualify with |valid.
    function automatic int unsigned rr_pick(
        input logic [7:0]  valid,
        input int unsigned ptr,
        input int unsigned nreq
    );
        int unsigned result;
        int unsigned cand;
        logic        found;
        result = 0;
        found  = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (k < nreq && !found) begin
                cand = ptr + k;
                if (cand >= nreq) cand = cand - nreq;
                if (valid[cand[2:0]]) begin
                    result = cand;
                    found  = 1'b1;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mul_core.sv
// Unsigned shift-add multiplier: the first iteration is folded into the start
// edge so the product is ready exactly WIDTH cycles after start.
module mul_core #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    logic                 r_busy;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   w_a_ext;

    assign w_a_ext = {{WIDTH{1'b0}}, a};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (start && !r_busy) begin
            r_acc    <= b[0] ? w_a_ext : '0;
            r_mcand  <= w_a_ext << 1;
            r_mplier <= b >> 1;
            r_cnt    <= CNT_INIT;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end else begin
                if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - CW'(1);
            end
        end
    end

    // All WIDTH iterations are complete while the counter sits at zero.
    assign done    = r_busy && (r_cnt == '0);
    assign product = r_acc;

endmodule

// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one mul_core between NREQ requesters, with a
// single held response buffer tagged by requester ID.
module mul_sched
    import mul_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    output logic [IDW-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]      rsp_product,
    input  logic                    rsp_ready,
    output logic                    busy,
    output state_t                  dbg_state
);

    // Request handshake: a requester is accepted on the edge where its
    // req_valid and req_ready are both high; req_ready is only offered in IDLE.
    // Response handshake: rsp_valid holds id/product stable until rsp_ready.

    state_t               r_state;
    state_t               w_next;
    logic [IDW-1:0]       r_ptr;
    logic [IDW-1:0]       r_rsp_id;
    logic [2*WIDTH-1:0]   r_rsp_product;

    logic [IDW-1:0]       w_gid;
    logic [NREQ-1:0]      w_grant;
    logic                 w_hs;
    logic [WIDTH-1:0]     w_a_sel;
    logic [WIDTH-1:0]     w_b_sel;
    logic [2*WIDTH-1:0]   w_core_product;
    logic                 w_core_done;

    assign w_gid = IDW'(rr_pick(8'(req_valid), 32'(r_ptr), 32'(NREQ)));

    always_comb begin
        w_grant = '0;
        if (r_state == ST_IDLE && |req_valid) w_grant[w_gid] = 1'b1;
    end

    assign w_hs    = |w_grant;
    assign w_a_sel = req_a[32'(w_gid)*WIDTH +: WIDTH];
    assign w_b_sel = req_b[32'(w_gid)*WIDTH +: WIDTH];

    mul_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .rst     (rst),
        .start   (w_hs),
        .a       (w_a_sel),
        .b       (w_b_sel),
        .product (w_core_product),
        .done    (w_core_done)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_hs)        w_next = ST_RUN;
            ST_RUN:  if (w_core_done) w_next = ST_RESP;
            ST_RESP: if (rsp_ready)   w_next = ST_IDLE;
            default:                  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_rsp_id      <= '0;
            r_rsp_product <= '0;
        end else begin
            r_state <= w_next;
            if (w_hs) begin
                r_rsp_id <= w_gid;
                r_ptr    <= (w_gid == IDW'(NREQ - 1)) ? '0 : w_gid + IDW'(1);
            end
            if (r_state == ST_RUN && w_core_done) r_rsp_product <= w_core_product;
        end
    end

    assign req_ready   = w_grant;
    assign rsp_valid   = (r_state == ST_RESP);
    assign rsp_id      = r_rsp_id;
    assign rsp_product = r_rsp_product;
    assign busy        = (r_state != ST_IDLE);
    assign dbg_state   = r_state;

endmodule
